// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch core. Outputs are registered one clk after the causing input; there is no backpressure.
// Optional `STOPWATCH_SATURATE_EN: at the ceiling, hold the time and pause instead of rolling over to 00:00.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       clr,
  input  logic       pause_tgl,
  input  logic       adj,
  input  logic [1:0] adj_sel,
  input  logic [3:0] adj_num,
  output logic [3:0] min_l,
  output logic [3:0] min_r,
  output logic [3:0] sec_l,
  output logic [3:0] sec_r,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_ADJUST} state_t;

  localparam logic [7:0] PRE_LAST  = 8'(TICK_DIV - 1);
  localparam logic [3:0] MIN_L_MAX = 4'(MIN_TENS_MAX);

  state_t     state_q, state_d;
  logic [7:0] pre_q, pre_d;
  logic [3:0] min_l_q, min_l_d, min_r_q, min_r_d;
  logic [3:0] sec_l_q, sec_l_d, sec_r_q, sec_r_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;
  logic       inc, at_max, sat_stop;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign at_max = (min_l_q == MIN_L_MAX) && (min_r_q == 4'd9) &&
                  (sec_l_q == 4'd5) && (sec_r_q == 4'd9);

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    min_l_d  = min_l_q;
    min_r_d  = min_r_q;
    sec_l_d  = sec_l_q;
    sec_r_d  = sec_r_q;
    wrap_d   = 1'b0;
    inc      = 1'b0;
    sat_stop = 1'b0;

    // Prescaler only advances while running; pausing preserves a partial count.
    if (state_q == ST_RUN && tick_1hz) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        inc   = 1'b1;
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end

    if (inc) begin
      if (at_max) begin
        wrap_d = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
        sat_stop = 1'b1;
`else
        min_l_d = '0;
        min_r_d = '0;
        sec_l_d = '0;
        sec_r_d = '0;
`endif
      end else if (sec_r_q != 4'd9) begin
        sec_r_d = sec_r_q + 4'd1;
      end else begin
        sec_r_d = '0;
        if (sec_l_q != 4'd5) begin
          sec_l_d = sec_l_q + 4'd1;
        end else begin
          sec_l_d = '0;
          if (min_r_q != 4'd9) begin
            min_r_d = min_r_q + 4'd1;
          end else begin
            min_r_d = '0;
            min_l_d = min_l_q + 4'd1;
          end
        end
      end
    end

    if (state_q == ST_ADJUST) begin
      case (adj_sel)
        2'd0:    sec_r_d = clamp(adj_num, 4'd9);
        2'd1:    sec_l_d = clamp(adj_num, 4'd5);
        2'd2:    min_r_d = clamp(adj_num, 4'd9);
        default: min_l_d = clamp(adj_num, MIN_L_MAX);
      endcase
    end

    // clr beats both a same-cycle increment and an adjust load.
    if (clr) begin
      pre_d    = '0;
      min_l_d  = '0;
      min_r_d  = '0;
      sec_l_d  = '0;
      sec_r_d  = '0;
      wrap_d   = 1'b0;
      sat_stop = 1'b0;
    end

    if (adj) begin
      state_d = ST_ADJUST;
    end else if (state_q == ST_ADJUST) begin
      state_d = ST_PAUSED;
    end else if (sat_stop) begin
      state_d = ST_PAUSED;
    end else if (pause_tgl) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PAUSED;
      pre_q     <= '0;
      min_l_q   <= '0;
      min_r_q   <= '0;
      sec_l_q   <= '0;
      sec_r_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      min_l_q   <= min_l_d;
      min_r_q   <= min_r_d;
      sec_l_q   <= sec_l_d;
      sec_r_q   <= sec_r_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign min_l   = min_l_q;
  assign min_r   = min_r_q;
  assign sec_l   = sec_l_q;
  assign sec_r   = sec_r_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule
